// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter sharing one down-counter among N requesters.
// The owner holds the counter for len+1 cycles, then gets a one-cycle done pulse.
module shared_counter_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   cnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] w_q, w_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;

  logic [PW-1:0] win;
  logic          win_vld;
  logic [W-1:0]  win_len;
  int            idx;

  // First requester at or above ptr, wrapping around.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!win_vld && req[idx[PW-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) win_len = len[i*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          state_d = COUNT;
          w_d     = win;
          gnt_d   = N'(1) << win;
          cnt_d   = win_len;
          ptr_d   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
      end
      COUNT: begin
        // Owner dropping its request wins over reaching zero.
        if (!req[w_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - W'(1);
        end else begin
          state_d = RELEASE;
          gnt_d   = '0;
          done_d  = N'(1) << w_q;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Bench for shared_counter_arbiter: cycle model of the arbitration rules,
// grant-order scoreboard and directed scenarios with literal expectations.
module tb_shared_counter_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [W-1:0]   len_a [N];
  logic [N*W-1:0] len;
  logic [N-1:0]   gnt, done;
  logic           busy;
  logic [W-1:0]   cnt;

  for (genvar g = 0; g < N; g++) begin : g_len
    assign len[g*W +: W] = len_a[g];
  end

  shared_counter_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len),
    .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  // Model: who owns the counter, how much is left, and whether a done is showing.
  int           m_owner = -1;
  int           m_rem = 0;
  int           m_ptr = 0;
  bit           m_release = 1'b0;
  logic [N-1:0] exp_gnt = '0;
  logic [N-1:0] exp_done = '0;
  logic [W-1:0] exp_cnt = '0;
  logic         exp_busy = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_rem = 0; m_ptr = 0; m_release = 1'b0;
      exp_gnt = '0; exp_done = '0; exp_cnt = '0;
    end else if (m_release) begin
      m_release = 1'b0;
      exp_done  = '0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        exp_gnt = '0;
        exp_cnt = '0;
      end else if (m_rem > 0) begin
        m_rem   = m_rem - 1;
        exp_cnt = W'(m_rem);
      end else begin
        exp_done  = N'(1) << m_owner;
        exp_gnt   = '0;
        m_owner   = -1;
        m_release = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_rem   = int'(len_a[m_owner]);
          exp_cnt = len_a[m_owner];
          exp_gnt = N'(1) << m_owner;
          m_ptr   = (m_owner + 1) % N;
        end
      end
    end
    exp_busy = (m_owner >= 0) || m_release;
  end

  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("done", 32'(done), 32'(exp_done));
      check("busy", 32'(busy), 32'(exp_busy));
      check("cnt", 32'(cnt), 32'(exp_cnt));
      if (gnt != '0 && prev_gnt == '0) begin
        int gi;
        gi = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
        if (exp_q.size() == 0) begin
          check("order_unexpected", 32'(gi), 32'hFFFF_FFFF);
        end else begin
          check("order", 32'(gi), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    for (int i = 0; i < N; i++) len_a[i] = '0;
    step();
    step();
    chk_en = 1'b1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(cnt), 0);

    // Single request of length 3.
    do_reset();
    req = 4'b0001; len_a[0] = 8'd3;
    exp_q.push_back(2'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("single_gnt", 32'(gnt), 32'h1);
      check("single_cnt", 32'(cnt), 32'(4 - c));
    end
    step();
    check("single_done", 32'(done), 32'h1);
    check("single_gnt_low", 32'(gnt), 0);
    req = '0;
    step();
    check("single_done_once", 32'(done), 0);
    check("single_busy_low", 32'(busy), 0);

    // Round-robin with all lengths zero.
    do_reset();
    for (int i = 0; i < N; i++) len_a[i] = '0;
    req = 4'b1111;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int c = 1; c <= 14; c++) begin
      logic [N-1:0] g, d;
      step();
      g = (c % 3 == 1) ? N'(1) << (((c - 1) / 3) % N) : '0;
      d = (c % 3 == 2) ? N'(1) << (((c - 2) / 3) % N) : '0;
      check("rr_gnt", 32'(gnt), 32'(g));
      check("rr_done", 32'(done), 32'(d));
    end
    req = '0;
    step();

    // Pointer wrap: grant 1, then 1001 must serve 3 before 0.
    do_reset();
    req = 4'b0010;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    step(); check("wrap_g1", 32'(gnt), 32'h2);
    step(); check("wrap_d1", 32'(done), 32'h2);
    req = '0;
    step();
    req = 4'b1001;
    step(); check("wrap_g3", 32'(gnt), 32'h8);
    step(); check("wrap_d3", 32'(done), 32'h8);
    step(); check("wrap_idle", 32'(busy), 0);
    step(); check("wrap_g0", 32'(gnt), 32'h1);
    step(); check("wrap_d0", 32'(done), 32'h1);
    req = '0;
    step();
    step();

    // Abort while cnt = 6.
    do_reset();
    req = 4'b0100; len_a[2] = 8'd10;
    exp_q.push_back(2'd2);
    for (int c = 1; c <= 5; c++) step();
    check("abort_cnt6", 32'(cnt), 32'd6);
    req = '0;
    step();
    check("abort_gnt", 32'(gnt), 0);
    check("abort_cnt", 32'(cnt), 0);
    check("abort_busy", 32'(busy), 0);
    step();
    check("abort_no_done", 32'(done), 0);

    // Reset mid-count; pointer must restart at 0.
    do_reset();
    req = 4'b0010; len_a[1] = 8'd8;
    exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    for (int c = 1; c <= 4; c++) step();
    check("mrst_cnt5", 32'(cnt), 32'd5);
    rst = 1'b1;
    for (int i = 0; i < N; i++) len_a[i] = '0;
    req = 4'b1111;
    step();
    check("mrst_gnt", 32'(gnt), 0);
    check("mrst_cnt", 32'(cnt), 0);
    check("mrst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();
    check("mrst_g0", 32'(gnt), 32'h1);
    req = '0;
    step();

    // Maximum length; late len change is ignored.
    do_reset();
    req = 4'b0001; len_a[0] = 8'd255;
    exp_q.push_back(2'd0);
    begin
      int hi;
      step();
      check("max_cnt_start", 32'(cnt), 32'd255);
      hi = (gnt == 4'b0001) ? 1 : 0;
      len_a[0] = 8'd7;
      for (int c = 2; c <= 256; c++) begin
        step();
        if (gnt == 4'b0001) hi++;
      end
      check("max_cnt_end", 32'(cnt), 0);
      check("max_gnt_cycles", 32'(hi), 32'd256);
    end
    step();
    check("max_done", 32'(done), 32'h1);
    check("max_cnt_nowrap", 32'(cnt), 0);
    req = '0;
    step();
    check("max_busy_low", 32'(busy), 0);
    step();

    check("order_left", 32'(exp_q.size()), 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
